// File: rtl/demosaic_pkg.sv
// Shared types for the demosaic frame controller: sequencer states and
// error codes reported to the system controller.
package demosaic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    INGEST = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SHORT   = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/demosaic_frame_ctrl.sv
// Frame sequencer in front of demosaic: admits whole camera frames on a vsync
// edge, forwards pixels with one cycle of latency and waits for the RGB drain.
module demosaic_frame_ctrl
  import demosaic_pkg::*;
#(
  parameter int DISP_WIDTH    = 640,
  parameter int DISP_HIGHT    = 480,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_enable,
  input  logic        cam_vsync,
  input  logic        data_in_valid,
  input  logic [7:0]  data_in,
  output logic        dm_vsync,
  output logic        dm_valid,
  output logic [7:0]  dm_data,
  input  logic        dm_out_valid,
  output logic        busy,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_cnt
);

  localparam int NPIX = DISP_WIDTH * DISP_HIGHT;
  localparam int XW   = (DISP_WIDTH > 1) ? $clog2(DISP_WIDTH) : 1;
  localparam int YW   = (DISP_HIGHT > 1) ? $clog2(DISP_HIGHT) : 1;
  localparam int CW   = $clog2(NPIX + 1);
  localparam int TW   = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [XW-1:0] X_LAST = XW'(DISP_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(DISP_HIGHT - 1);
  localparam logic [CW-1:0] C_LAST = CW'(NPIX - 1);
  localparam logic [TW-1:0] T_LAST = TW'(DRAIN_TIMEOUT - 1);

  state_e          state_q;
  logic            vs_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [CW-1:0]   out_cnt_q;
  logic [TW-1:0]   idle_q;
  logic            ovr_q;
  logic            dm_vsync_q;
  logic            dm_valid_q;
  logic [7:0]      dm_data_q;
  logic            busy_q;
  logic            start_q;
  logic            done_q;
  logic            err_q;
  logic [1:0]      err_code_q;
  logic [15:0]     frame_cnt_q;

  logic vs_rise;
  logic px_last;
  logic drain_done;
  logic drain_tout;

  assign vs_rise    = cam_vsync & ~vs_q;
  assign px_last    = (x_q == X_LAST) && (y_q == Y_LAST);
  assign drain_done = dm_out_valid && (out_cnt_q == C_LAST);
  assign drain_tout = !dm_out_valid && (idle_q == T_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vs_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      out_cnt_q   <= '0;
      idle_q      <= '0;
      ovr_q       <= 1'b0;
      dm_vsync_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      dm_data_q   <= 8'd0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      frame_cnt_q <= 16'd0;
    end else begin
      // The edge register tracks vsync in every state, so an edge seen while
      // idle or draining is consumed and never admits a frame later.
      vs_q       <= cam_vsync;
      dm_vsync_q <= (state_q != IDLE) && cam_vsync;
      dm_valid_q <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;

      case (state_q)
        IDLE: begin
          if (cfg_enable) state_q <= ARM;
        end

        ARM: begin
          if (!cfg_enable) begin
            state_q <= IDLE;
          end else if (vs_rise) begin
            state_q <= INGEST;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
            ovr_q   <= 1'b0;
          end
        end

        INGEST: begin
          if (vs_rise) begin
            // Short frame: the same edge restarts capture when still enabled.
            err_q      <= 1'b1;
            err_code_q <= ERR_SHORT;
            x_q        <= '0;
            y_q        <= '0;
            ovr_q      <= 1'b0;
            if (cfg_enable) begin
              start_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (data_in_valid) begin
            dm_valid_q <= 1'b1;
            dm_data_q  <= data_in;
            if (x_q == X_LAST) begin
              x_q <= '0;
              y_q <= y_q + 1'b1;
            end else begin
              x_q <= x_q + 1'b1;
            end
            if (px_last) begin
              state_q   <= DRAIN;
              out_cnt_q <= '0;
              idle_q    <= '0;
            end
          end
        end

        DRAIN: begin
          if (data_in_valid && !ovr_q) begin
            ovr_q      <= 1'b1;
            err_q      <= 1'b1;
            err_code_q <= ERR_OVERRUN;
          end
          if (dm_out_valid) begin
            out_cnt_q <= out_cnt_q + 1'b1;
            idle_q    <= '0;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
          if (drain_done || drain_tout) begin
            state_q <= cfg_enable ? ARM : IDLE;
            busy_q  <= 1'b0;
            if (drain_done) begin
              done_q      <= 1'b1;
              frame_cnt_q <= frame_cnt_q + 16'd1;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_TIMEOUT;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign dm_vsync    = dm_vsync_q;
  assign dm_valid    = dm_valid_q;
  assign dm_data     = dm_data_q;
  assign busy        = busy_q;
  assign frame_start = start_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign err_code    = err_code_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_demosaic_frame_ctrl.sv
// Self-checking bench for demosaic_frame_ctrl: a frame-level reference model
// is compared against the DUT every cycle, plus directed literal checks.
module tb_demosaic_frame_ctrl;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int TO   = 16;
  localparam int NPIX = W * H;

  localparam int M_OFF   = 0;
  localparam int M_WAIT  = 1;
  localparam int M_TAKE  = 2;
  localparam int M_DRAIN = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_enable = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        data_in_valid = 1'b0;
  logic [7:0]  data_in = 8'd0;
  logic        dm_out_valid = 1'b0;
  logic        dm_vsync;
  logic        dm_valid;
  logic [7:0]  dm_data;
  logic        busy;
  logic        frame_start;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;

  demosaic_frame_ctrl #(
    .DISP_WIDTH   (W),
    .DISP_HIGHT   (H),
    .DRAIN_TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_enable   (cfg_enable),
    .cam_vsync    (cam_vsync),
    .data_in_valid(data_in_valid),
    .data_in      (data_in),
    .dm_vsync     (dm_vsync),
    .dm_valid     (dm_valid),
    .dm_data      (dm_data),
    .dm_out_valid (dm_out_valid),
    .busy         (busy),
    .frame_start  (frame_start),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .err_code     (err_code),
    .frame_cnt    (frame_cnt)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame-level bookkeeping with plain integer counts.
  int         mode = M_OFF;
  int         pix = 0;
  int         outs = 0;
  int         silent = 0;
  bit         ovr = 1'b0;
  bit         prev_vs = 1'b0;
  bit         e_vs = 1'b0, e_valid = 1'b0, e_busy = 1'b0;
  bit         e_start = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [7:0] e_data = 8'd0;
  logic [1:0] e_code = 2'd0;
  int         e_cnt = 0;

  initial forever begin
    bit rise;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mode = M_OFF; pix = 0; outs = 0; silent = 0; ovr = 0; prev_vs = 0;
      e_vs = 0; e_valid = 0; e_busy = 0; e_start = 0; e_done = 0; e_err = 0;
      e_data = 8'd0; e_code = 2'd0; e_cnt = 0;
    end else begin
      rise = cam_vsync && !prev_vs;
      prev_vs = cam_vsync;
      e_vs = (mode != M_OFF) && cam_vsync;
      e_valid = 0; e_start = 0; e_done = 0; e_err = 0;
      case (mode)
        M_OFF: if (cfg_enable) mode = M_WAIT;
        M_WAIT: begin
          if (!cfg_enable) mode = M_OFF;
          else if (rise) begin mode = M_TAKE; pix = 0; ovr = 0; e_start = 1; end
        end
        M_TAKE: begin
          if (rise) begin
            e_err = 1; e_code = 2'd1; pix = 0; ovr = 0;
            if (cfg_enable) e_start = 1; else mode = M_OFF;
          end else if (data_in_valid) begin
            e_valid = 1; e_data = data_in; pix++;
            if (pix == NPIX) begin mode = M_DRAIN; outs = 0; silent = 0; end
          end
        end
        default: begin
          if (data_in_valid && !ovr) begin ovr = 1; e_err = 1; e_code = 2'd2; end
          if (dm_out_valid) begin outs++; silent = 0; end else silent++;
          if (outs == NPIX || silent == TO) begin
            if (outs == NPIX) begin e_done = 1; e_cnt = (e_cnt + 1) % 65536; end
            else begin e_err = 1; e_code = 2'd3; end
            mode = cfg_enable ? M_WAIT : M_OFF;
          end
        end
      endcase
      e_busy = (mode == M_TAKE) || (mode == M_DRAIN);
    end
  end

  // Per-cycle compare plus event monitors, sampled on the falling edge.
  int n_start = 0, n_done = 0, n_err = 0, n_fwd = 0, n_vs = 0, n_both = 0;

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("dm_vsync", dm_vsync, e_vs);
      chk("dm_valid", dm_valid, e_valid);
      if (e_valid) chk("dm_data", dm_data, e_data);
      chk("busy", busy, e_busy);
      chk("frame_start", frame_start, e_start);
      chk("frame_done", frame_done, e_done);
      chk("frame_err", frame_err, e_err);
      chk("err_code", err_code, e_code);
      chk("frame_cnt", frame_cnt, e_cnt);
    end
    n_start += frame_start;
    n_done  += frame_done;
    n_err   += frame_err;
    n_fwd   += dm_valid;
    n_vs    += dm_vsync;
    if (frame_start && frame_err) n_both++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_mon();
    n_start = 0; n_done = 0; n_err = 0; n_fwd = 0; n_vs = 0; n_both = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    tick();
    rst_n = 0; cfg_enable = 0; cam_vsync = 0; data_in_valid = 0; dm_out_valid = 0;
    idle(3);
    rst_n = 1;
    tick();
    clr_mon();
  endtask

  task automatic vs_pulse();
    tick(); cam_vsync = 1; data_in_valid = 0;
    tick(); cam_vsync = 0;
  endtask

  task automatic send_pix(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin tick(); data_in_valid = 0; end
      tick(); data_in_valid = 1; data_in = 8'($urandom);
    end
    tick(); data_in_valid = 0;
  endtask

  // Pipeline stand-in: returns k RGB strobes with short random gaps.
  task automatic drain(input int k);
    idle(3);
    for (int i = 0; i < k; i++) begin
      repeat ($urandom_range(0, 2)) begin tick(); dm_out_valid = 0; end
      tick(); dm_out_valid = 1;
    end
    tick(); dm_out_valid = 0;
  endtask

  initial begin
    int k;
    do_reset();
    chk_on = 1;
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);

    // Clean frame
    cfg_enable = 1; idle(2);
    vs_pulse();
    chk("s1_start_pulse", frame_start, 1);
    chk("s1_vsync_fwd", dm_vsync, 1);
    send_pix(NPIX);
    drain(NPIX);
    idle(3);
    chk("s1_n_start", n_start, 1);
    chk("s1_n_fwd", n_fwd, NPIX);
    chk("s1_n_done", n_done, 1);
    chk("s1_frame_cnt", frame_cnt, 1);
    chk("s1_busy_low", busy, 0);

    // Short frame then a full one
    do_reset();
    cfg_enable = 1; idle(2);
    vs_pulse();
    send_pix(20);
    vs_pulse();
    chk("s2_short_err", frame_err, 1);
    chk("s2_short_restart", frame_start, 1);
    chk("s2_short_code", err_code, 1);
    send_pix(NPIX);
    drain(NPIX);
    idle(3);
    chk("s2_n_both", n_both, 1);
    chk("s2_n_done", n_done, 1);
    chk("s2_frame_cnt", frame_cnt, 1);

    // Overrun
    do_reset();
    cfg_enable = 1; idle(2);
    vs_pulse();
    send_pix(NPIX + 3);
    drain(NPIX);
    idle(3);
    chk("s3_n_fwd", n_fwd, NPIX);
    chk("s3_n_err", n_err, 1);
    chk("s3_code", err_code, 2);
    chk("s3_frame_cnt", frame_cnt, 1);

    // Drain timeout after 30 outputs
    do_reset();
    cfg_enable = 1; idle(2);
    vs_pulse();
    send_pix(NPIX);
    drain(NPIX - 2);
    k = -1;
    for (int i = 1; i <= 40 && k < 0; i++) begin
      tick();
      if (frame_err) k = i;
    end
    chk("s4_timeout_latency", k, TO);
    chk("s4_code", err_code, 3);
    chk("s4_frame_cnt", frame_cnt, 0);
    chk("s4_busy_low", busy, 0);
    idle(2);
    vs_pulse();
    chk("s4_rearmed", frame_start, 1);

    // Disable mid-frame: frame completes, then idle
    do_reset();
    cfg_enable = 1; idle(2);
    vs_pulse();
    send_pix(10);
    cfg_enable = 0;
    send_pix(NPIX - 10);
    drain(NPIX);
    idle(3);
    chk("s5_frame_cnt", frame_cnt, 1);
    chk("s5_busy_low", busy, 0);
    clr_mon();
    vs_pulse(); send_pix(5); vs_pulse(); idle(3);
    chk("s5_no_vsync", n_vs, 0);
    chk("s5_no_fwd", n_fwd, 0);
    chk("s5_no_start", n_start, 0);

    // Asynchronous reset mid-ingest
    cfg_enable = 1; idle(2);
    vs_pulse();
    send_pix(10);
    tick(); cam_vsync = 1; data_in_valid = 1; data_in = 8'hA5;
    #1 rst_n = 0;
    #1;
    chk("r_dm_vsync", dm_vsync, 0);
    chk("r_dm_valid", dm_valid, 0);
    chk("r_dm_data", dm_data, 0);
    chk("r_busy", busy, 0);
    chk("r_pulses", {frame_start, frame_done, frame_err}, 0);
    chk("r_err_code", err_code, 0);
    chk("r_frame_cnt", frame_cnt, 0);
    data_in_valid = 0;
    idle(3);
    rst_n = 1;
    clr_mon();
    for (int i = 0; i < 8; i++) begin tick(); data_in_valid = i[0]; end
    tick(); data_in_valid = 0; cam_vsync = 0;
    idle(2);
    chk("r_no_start_held_vsync", n_start, 0);
    chk("r_no_fwd_held_vsync", n_fwd, 0);
    vs_pulse();
    chk("r_fresh_edge_start", frame_start, 1);
    send_pix(NPIX);
    drain(NPIX);
    idle(3);
    chk("r_frame_cnt_after", frame_cnt, 1);

    // Random soak against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 63) == 0) cfg_enable = ~cfg_enable;
      if (cam_vsync) cam_vsync = ($urandom_range(0, 2) != 0);
      else           cam_vsync = ($urandom_range(0, 39) == 0);
      data_in_valid = $urandom_range(0, 1);
      data_in       = 8'($urandom);
      dm_out_valid  = ($urandom_range(0, 7) < 5);
      if ($urandom_range(0, 499) == 0) dm_out_valid = 0;
    end
    tick();
    data_in_valid = 0; dm_out_valid = 0; cam_vsync = 0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
